reservoir_level_model: RTL and testbench

Behavioural plant model for the reservoir flow-rate controller: consumes the controller's valve commands (fr2, fr1, fr0, dfr) and a per-tick drain demand. It integrates a saturating water level and produces the registered thermometer-coded level sensors s[2:0] with hysteresis. It also flags overflow, underflow and illegal valve command codes. It sits on the opposite side of the sensor/valve interface from the controller and closes the loop in system-level simulation and FPGA demo builds.

---
 rtl/reservoir_level_model.sv | 108 ++++++++++
 tb/tb_reservoir_level_model.sv | 188 ++++++++++++++++++
 2 files changed

// File: rtl/reservoir_level_model.sv
// Behavioural plant model of a reservoir: integrates valve inflow minus drain into a
// saturating level and drives thermometer-coded level sensors with rising hysteresis.
module reservoir_level_model #(
  parameter int LEVEL_W    = 10,
  parameter int MAX_LEVEL  = 1000,
  parameter int T1         = 250,
  parameter int T2         = 500,
  parameter int T3         = 750,
  parameter int HYST       = 8,
  parameter int FR_RATE    = 4,
  parameter int DFR_RATE   = 4,
  parameter int DRAIN_W    = 4,
  parameter int INIT_LEVEL = 0
) (
  input  logic               clk,
  input  logic               aresetn,
  input  logic               fr2,
  input  logic               fr1,
  input  logic               fr0,
  input  logic               dfr,
  input  logic [DRAIN_W-1:0] drain,
  input  logic               tick,
  input  logic               load,
  input  logic [LEVEL_W-1:0] load_level,
  output logic [2:0]         s,
  output logic [LEVEL_W-1:0] level,
  output logic               overflow,
  output logic               underflow,
  output logic               illegal_cmd
);

  localparam int SW = LEVEL_W + 3;
  localparam logic signed [SW-1:0] MaxS = SW'(MAX_LEVEL);

  logic [LEVEL_W-1:0]   r_level;
  logic [2:0]           r_s;
  logic                 r_overflow;
  logic                 r_underflow;
  logic                 r_illegal;

  logic [1:0]           w_frCount;
  logic signed [SW-1:0] w_inflow;
  logic signed [SW-1:0] w_sum;
  logic                 w_sumHigh;
  logic                 w_sumLow;
  logic [LEVEL_W-1:0]   w_tickLevel;
  logic [LEVEL_W-1:0]   w_loadClamped;
  logic [2:0]           w_sLoad;
  logic [2:0]           w_sTick;
  logic                 w_codeLegal;

  function automatic logic [2:0] thermoCode(input logic [LEVEL_W-1:0] lvl, input int offset);
    int l;
    l = int'(lvl);
    thermoCode = {l >= T3 + offset, l >= T2 + offset, l >= T1 + offset};
  endfunction

  // Level arithmetic is widened by 3 bits so overshoot and undershoot never wrap.
  assign w_frCount     = {1'b0, fr0} + {1'b0, fr1} + {1'b0, fr2};
  assign w_inflow      = $signed(SW'(FR_RATE)) * $signed({{(SW-2){1'b0}}, w_frCount})
                       + (dfr ? $signed(SW'(DFR_RATE)) : $signed(SW'(0)));
  assign w_sum         = $signed({3'b000, r_level}) + w_inflow
                       - $signed({{(SW-DRAIN_W){1'b0}}, drain});
  assign w_sumHigh     = w_sum > MaxS;
  assign w_sumLow      = w_sum[SW-1];
  assign w_tickLevel   = w_sumHigh ? LEVEL_W'(MAX_LEVEL) :
                         w_sumLow  ? '0 : w_sum[LEVEL_W-1:0];
  assign w_loadClamped = (load_level > LEVEL_W'(MAX_LEVEL)) ? LEVEL_W'(MAX_LEVEL) : load_level;

  // A set sensor holds until the level drops below its threshold; a clear one
  // waits for threshold plus the hysteresis margin.
  assign w_sLoad = thermoCode(w_loadClamped, 0);
  assign w_sTick = (r_s & thermoCode(w_tickLevel, 0)) | (~r_s & thermoCode(w_tickLevel, HYST));

  always_comb begin
    w_codeLegal = 1'b0;
    case ({fr2, fr1, fr0, dfr})
      4'b1111, 4'b0110, 4'b0111, 4'b0010, 4'b0011, 4'b0000: w_codeLegal = 1'b1;
      default: w_codeLegal = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge aresetn) begin
    if (!aresetn) begin
      r_level     <= LEVEL_W'(INIT_LEVEL);
      r_s         <= 3'b000;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
      r_illegal   <= 1'b0;
    end else if (load) begin
      r_level <= w_loadClamped;
      r_s     <= w_sLoad;
    end else if (tick) begin
      r_level <= w_tickLevel;
      r_s     <= w_sTick;
      if (w_sumHigh)    r_overflow  <= 1'b1;
      if (w_sumLow)     r_underflow <= 1'b1;
      if (!w_codeLegal) r_illegal   <= 1'b1;
    end
  end

  assign level       = r_level;
  assign s           = r_s;
  assign overflow    = r_overflow;
  assign underflow   = r_underflow;
  assign illegal_cmd = r_illegal;

endmodule

// File: tb/tb_reservoir_level_model.sv
// Self-checking bench for reservoir_level_model: directed table, hand sequences for
// reset and hysteresis corners, and a randomized run against a plain-arithmetic model.
module tb_reservoir_level_model;

  logic       clk = 1'b0;
  logic       aresetn = 1'b0;
  logic       fr2 = 0, fr1 = 0, fr0 = 0, dfr = 0;
  logic [3:0] drain = '0;
  logic       tick = 0, load = 0;
  logic [9:0] load_level = '0;
  logic [2:0] s;
  logic [9:0] level;
  logic       overflow, underflow, illegal_cmd;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int   mLevel;
  logic [2:0] mS;
  logic mOvf, mUnf, mIll;
  int   thr[3] = '{250, 500, 750};
  int   legalCodes[6] = '{15, 6, 7, 2, 3, 0};

  typedef struct {
    logic       ld;
    int         ll;
    logic       tk;
    logic [3:0] v;
    int         dr;
    int         eLevel;
    logic [2:0] eS;
    logic       eOvf;
    logic       eUnf;
    logic       eIll;
  } vec_t;

  vec_t vecs[15];

  reservoir_level_model dut (
    .clk(clk), .aresetn(aresetn),
    .fr2(fr2), .fr1(fr1), .fr0(fr0), .dfr(dfr),
    .drain(drain), .tick(tick), .load(load), .load_level(load_level),
    .s(s), .level(level), .overflow(overflow), .underflow(underflow),
    .illegal_cmd(illegal_cmd)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached (actual=timeout, required=finish)");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAll(input string tag, input int eLevel, input logic [2:0] eS,
                          input logic eOvf, input logic eUnf, input logic eIll);
    checkOutput({tag, ".level"}, int'(level), eLevel);
    checkOutput({tag, ".s"}, int'(s), int'(eS));
    checkOutput({tag, ".overflow"}, int'(overflow), int'(eOvf));
    checkOutput({tag, ".underflow"}, int'(underflow), int'(eUnf));
    checkOutput({tag, ".illegal"}, int'(illegal_cmd), int'(eIll));
  endtask

  task automatic applyStimulus(input logic ld, input int ll, input logic tk,
                               input logic [3:0] v, input int dr);
    load       = ld;
    load_level = 10'(ll);
    tick       = tk;
    {fr2, fr1, fr0, dfr} = v;
    drain      = 4'(dr);
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    load = 0; tick = 0;
    @(negedge clk);
    aresetn = 0;
    #2;
    aresetn = 1;
    mLevel = 0; mS = 3'b000; mOvf = 0; mUnf = 0; mIll = 0;
  endtask

  task automatic modelStep(input logic ld, input int ll, input logic tk,
                           input logic [3:0] v, input int dr);
    int sum;
    bit legal;
    if (ld) begin
      mLevel = (ll > 1000) ? 1000 : ll;
      for (int i = 0; i < 3; i++) mS[i] = (mLevel >= thr[i]);
    end else if (tk) begin
      sum = mLevel + 4 * (int'(v[3]) + int'(v[2]) + int'(v[1])) + 4 * int'(v[0]) - dr;
      if (sum > 1000) begin
        mLevel = 1000; mOvf = 1;
      end else if (sum < 0) begin
        mLevel = 0; mUnf = 1;
      end else begin
        mLevel = sum;
      end
      for (int i = 0; i < 3; i++) begin
        if (!mS[i] && mLevel >= thr[i] + 8) mS[i] = 1'b1;
        else if (mS[i] && mLevel < thr[i]) mS[i] = 1'b0;
      end
      legal = 0;
      foreach (legalCodes[k]) if (int'(v) == legalCodes[k]) legal = 1;
      if (!legal) mIll = 1;
    end
  endtask

  initial begin
    vecs[0]  = '{1, 260,  0, 4'b0000, 0,  260,  3'b001, 0, 0, 0};
    vecs[1]  = '{0, 0,    1, 4'b0000, 5,  255,  3'b001, 0, 0, 0};
    vecs[2]  = '{0, 0,    1, 4'b0000, 5,  250,  3'b001, 0, 0, 0};
    vecs[3]  = '{0, 0,    1, 4'b0000, 5,  245,  3'b000, 0, 0, 0};
    vecs[4]  = '{0, 0,    0, 4'b1111, 15, 245,  3'b000, 0, 0, 0};
    vecs[5]  = '{1, 3,    0, 4'b0000, 0,  3,    3'b000, 0, 0, 0};
    vecs[6]  = '{0, 0,    1, 4'b0000, 10, 0,    3'b000, 0, 1, 0};
    vecs[7]  = '{1, 995,  0, 4'b0000, 0,  995,  3'b111, 0, 1, 0};
    vecs[8]  = '{0, 0,    1, 4'b1111, 0,  1000, 3'b111, 1, 1, 0};
    vecs[9]  = '{0, 0,    1, 4'b0000, 0,  1000, 3'b111, 1, 1, 0};
    vecs[10] = '{1, 100,  0, 4'b0000, 0,  100,  3'b000, 1, 1, 0};
    vecs[11] = '{0, 0,    1, 4'b1000, 0,  104,  3'b000, 1, 1, 1};
    vecs[12] = '{1, 1023, 1, 4'b1111, 0,  1000, 3'b111, 1, 1, 1};
    vecs[13] = '{0, 0,    1, 4'b0110, 8,  1000, 3'b111, 1, 1, 1};
    vecs[14] = '{0, 0,    1, 4'b0011, 15, 993,  3'b111, 1, 1, 1};

    // Reset values and the 17-tick fill across the first threshold
    doReset();
    #1;
    checkAll("reset", 0, 3'b000, 0, 0, 0);
    for (int t = 1; t <= 17; t++) begin
      applyStimulus(0, 0, 1, 4'b1111, 0);
      if (t == 16) checkAll("fill16", 256, 3'b000, 0, 0, 0);
      if (t == 17) checkAll("fill17", 272, 3'b001, 0, 0, 0);
    end

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].ld, vecs[i].ll, vecs[i].tk, vecs[i].v, vecs[i].dr);
      checkAll($sformatf("vec%0d", i), vecs[i].eLevel, vecs[i].eS,
               vecs[i].eOvf, vecs[i].eUnf, vecs[i].eIll);
    end

    // Asynchronous reset pulse between edges, then simultaneous load and tick
    applyStimulus(1, 600, 0, 4'b0000, 0);
    checkAll("mid600", 600, 3'b011, 1, 1, 1);
    #2 aresetn = 0;
    #1 checkAll("asyncRst", 0, 3'b000, 0, 0, 0);
    #1 aresetn = 1;
    applyStimulus(1, 1023, 1, 4'b1111, 0);
    checkAll("loadTick", 1000, 3'b111, 0, 0, 0);

    // Illegal code presented without tick must not flag
    doReset();
    applyStimulus(0, 0, 0, 4'b1000, 0);
    applyStimulus(0, 0, 0, 4'b0101, 3);
    checkAll("illNoTick", 0, 3'b000, 0, 0, 0);

    // Randomized run against the reference model
    doReset();
    for (int n = 0; n < 800; n++) begin
      logic       rLd, rTk;
      int         rLl, rDr;
      logic [3:0] rV;
      rLd = ($urandom_range(0, 19) == 0);
      rLl = $urandom_range(0, 1023);
      rTk = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) != 0) rV = 4'(legalCodes[$urandom_range(0, 5)]);
      else rV = 4'($urandom_range(0, 15));
      rDr = $urandom_range(0, 15);
      modelStep(rLd, rLl, rTk, rV, rDr);
      applyStimulus(rLd, rLl, rTk, rV, rDr);
      checkAll($sformatf("rand%0d", n), mLevel, mS, mOvf, mUnf, mIll);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
